// File: rtl/stat_pkg.sv
// Shared numbering and defaults for the pipeline statistics unit and the display selector.
package stat_pkg;

    localparam int STAT_CNT_W     = 32;

    localparam int STAT_SEL_CYCLE = 0;
    localparam int STAT_SEL_EVT0  = 1;

    localparam int EVT_UNCOND     = 0;
    localparam int EVT_COND       = 1;
    localparam int EVT_TAKEN      = 2;
    localparam int EVT_LOADUSE    = 3;

    // Read-select / counter-slot index of event channel evt_idx.
    function automatic int stat_sel_of_evt(input int evt_idx);
        return STAT_SEL_EVT0 + evt_idx;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// One statistics counter with synchronous clear and a sticky overflow flag;
// on overflow it either holds at all-ones or wraps to zero depending on SAT_MODE.
module stat_counter #(
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (at_max) begin
                ovf   <= 1'b1;
                count <= (SAT_MODE != 0) ? count : '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_stat_unit.sv
// Pipeline statistics unit: cycle and event counters, halt lock, atomic
// snapshot into shadow registers and a registered shadow read port.
module perf_stat_unit
    import stat_pkg::*;
#(
    parameter  int NUM_EVT  = 4,
    parameter  int CNT_W    = STAT_CNT_W,
    parameter  int SAT_MODE = 1,
    localparam int SEL_W    = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               RST_n,
    input  logic               clr,
    input  logic               halt,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               snap,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_EVT:0]   ovf,
    output logic               LOCK
);

    localparam int NUM_CNT = NUM_EVT + 1;

    logic               count_en;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   live   [NUM_CNT];
    logic [CNT_W-1:0]   shadow [NUM_CNT];
    logic [CNT_W-1:0]   rd_next;

    assign count_en            = !LOCK && !clr;
    assign inc[STAT_SEL_CYCLE] = count_en;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt_inc
        assign inc[stat_sel_of_evt(g)] = count_en & evt[g];
    end

    for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
        stat_counter #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cnt (
            .clk   (clk),
            .rst_n (RST_n),
            .en    (inc[c]),
            .clr   (clr),
            .count (live[c]),
            .ovf   (ovf[c])
        );
    end

    // The halting cycle itself is still counted; the lock takes effect from the next edge.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            LOCK <= 1'b0;
        end else if (clr) begin
            LOCK <= 1'b0;
        end else if (halt) begin
            LOCK <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= live[i];
            end
        end
    end

    // Selects outside the implemented range read as zero.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                rd_next = shadow[k];
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: doc/perf_stat_unit.md
Name: perf_stat_unit

Overview:
Parametrised pipeline statistics unit, successor to the fixed CACU counter block in the pipelined CPU top level. It counts a free-running cycle total plus NUM_EVT independent event channels, e.g. unconditional jumps, conditional branches, taken branches and load-use stalls. It latches the CPU halt into a LOCK output that freezes the pipeline registers. Live counters are copied atomically into shadow registers on request, and a registered read port feeds the seven-segment display selector.

Parameters:
NUM_EVT, 4, number of event channels (1..15)
CNT_W, 32, width of every counter and shadow register (8..32)
SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
SEL_W (localparam), clog2(NUM_EVT+1), read-select width

Ports:
clk  in  1  CPU pipeline clock (the divided clock)
RST_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of live counters, overflow flags and lock
halt  in  1  halt indication from the MEM/WB stage
evt  in  NUM_EVT  per-channel event strobes, one count per cycle when high
snap  in  1  copy all live counters into shadow registers
rd_sel  in  SEL_W  0 = cycle shadow; k (1..NUM_EVT) = shadow of channel k-1
rd_data  out  CNT_W  registered shadow read data
ovf  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1
LOCK  out  1  sticky halt lock; freezes the pipeline and counting

Behaviour:
- Reset (RST_n low, asynchronous): clears all live counters, shadows, ovf, LOCK and rd_data. Nothing in the block is left unreset.
- Lock:
  - LOCK is set on the first clock edge where halt=1 and LOCK=0. It then stays high until reset or clr.
  - The cycle in which halt is first sampled is still counted. The cycle counter includes the halting cycle.
- Counting is enabled when LOCK=0 and clr=0.
  - Cycle counter: +1 every enabled clock.
  - Channel i: +1 on every enabled clock with evt[i]=1.
- Overflow, when a counter is at all-ones and an increment occurs:
  - SAT_MODE=1: the value holds at all-ones and the ovf bit is set.
  - SAT_MODE=0: the value becomes 0 and the ovf bit is set.
  - ovf bits are sticky until reset or clr.
- clr has priority over increment and lock-set in the same cycle. After the edge, live counters=0, ovf=0 and LOCK=0, even if halt=1 that cycle. Shadows are not affected by clr.
- Snapshot:
  - snap=1 copies the pre-edge live values into all shadows on the same edge.
  - Snapshot is atomic: every shadow reflects the same cycle.
  - snap together with an increment captures the pre-increment value.
  - snap together with clr captures the pre-clear values.
  - snap is honoured while LOCK=1, so final results can be frozen.
- Read:
  - rd_data is registered on every clock from shadow[rd_sel]. Latency is 1 cycle.
  - rd_sel > NUM_EVT gives 0.
  - When snap and a read of the same index fall in one cycle, rd_data shows the old shadow value. The new value appears one cycle later.
- Counters never change while LOCK=1 (except via clr). evt and halt are ignored while locked.
- No combinational path from any input to any output.

Decomposition:
- Shared package stat_pkg holds:
  - constants STAT_SEL_CYCLE=0 and STAT_SEL_EVT0=1;
  - a default CNT_W;
  - event-index names EVT_UNCOND, EVT_COND, EVT_TAKEN, EVT_LOADUSE (0..3), so the top level and the display selector share numbering.
- One sub-module, stat_counter: one CNT_W counter with en, clr, SAT_MODE and a sticky ovf flag. It is instantiated NUM_EVT+1 times through a generate loop. Shadows, lock and the read mux stay in perf_stat_unit.

Test Plan:
- Reset then idle: release RST_n, run 10 clocks with evt=0, snap on cycle 10, read sel 0 -> rd_data=10 one cycle after the read; channel reads return 0.
- Events: evt[2]=1 for 7 clocks, evt[0] on alternate clocks for 6 clocks, snap -> sel 3 reads 7 and sel 1 reads 3; rd_sel=5 (NUM_EVT=4) reads 0.
- Halt lock: halt pulses high on cycle 20 with evt[1] held at 1 -> LOCK=1 from cycle 21. Cycle and channel 1 counts freeze at their cycle-20 values through 30 more clocks; snap while locked returns those values.
- Saturate vs wrap with CNT_W=8: 300 evt[0] strobes. SAT_MODE=1 -> 255 and ovf[1]=1. SAT_MODE=0 -> 44 and ovf[1]=1.
- Simultaneous events: snap+clr in one cycle with channel 0 at 12 -> shadow=12, live=0, ovf cleared. clr+halt in one cycle -> LOCK stays 0.
- Async reset mid-run: RST_n low between clock edges while LOCK=1 -> LOCK, ovf, rd_data and all counters go to 0 immediately, without waiting for a clock edge.
